// File: rtl/ctrl_pkg.sv
// Shared encodings for the single-bus control sequencer:
// opcodes, ALU op codes, FSM states and instruction classes.
package ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_ADDI = 5'd9;
  localparam logic [4:0] OP_ANDI = 5'd10;
  localparam logic [4:0] OP_ORI  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd12;
  localparam logic [4:0] OP_DIV  = 5'd13;
  localparam logic [4:0] OP_NEG  = 5'd14;
  localparam logic [4:0] OP_NOT  = 5'd15;
  localparam logic [4:0] OP_LD   = 5'd16;
  localparam logic [4:0] OP_ST   = 5'd17;
  localparam logic [4:0] OP_MFHI = 5'd18;
  localparam logic [4:0] OP_MFLO = 5'd19;
  localparam logic [4:0] OP_NOP  = 5'd20;
  localparam logic [4:0] OP_HALT = 5'd21;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_SHR, ALU_SHRA, ALU_SHL, ALU_ROR,
    ALU_ROL, ALU_MUL, ALU_DIV, ALU_NEG,
    ALU_NOT, ALU_INC
  } alu_op_t;

  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_F3,
    S_T3, S_T4, S_T5, S_T6, S_T7,
    S_HALT, S_PAUSE, S_ABORT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_MULDIV, C_UNARY,
    C_LD, C_ST, C_MFHI, C_MFLO,
    C_NOP, C_HALT, C_BAD
  } class_t;

  function automatic class_t op_class(
    input logic [4:0] op
  );
    class_t c;
    unique case (1'b1)
      (op <= OP_ROL):
        c = C_ALU;
      (op >= OP_ADDI && op <= OP_ORI):
        c = C_IMM;
      (op == OP_MUL || op == OP_DIV):
        c = C_MULDIV;
      (op == OP_NEG || op == OP_NOT):
        c = C_UNARY;
      (op == OP_LD):   c = C_LD;
      (op == OP_ST):   c = C_ST;
      (op == OP_MFHI): c = C_MFHI;
      (op == OP_MFLO): c = C_MFLO;
      (op == OP_NOP):  c = C_NOP;
      (op == OP_HALT): c = C_HALT;
      default:         c = C_BAD;
    endcase
    return c;
  endfunction

  function automatic alu_op_t op_alu(
    input logic [4:0] op
  );
    alu_op_t a;
    unique case (op)
      OP_ADD, OP_ADDI: a = ALU_ADD;
      OP_SUB:          a = ALU_SUB;
      OP_AND, OP_ANDI: a = ALU_AND;
      OP_OR, OP_ORI:   a = ALU_OR;
      OP_SHR:          a = ALU_SHR;
      OP_SHRA:         a = ALU_SHRA;
      OP_SHL:          a = ALU_SHL;
      OP_ROR:          a = ALU_ROR;
      OP_ROL:          a = ALU_ROL;
      OP_MUL:          a = ALU_MUL;
      OP_DIV:          a = ALU_DIV;
      OP_NEG:          a = ALU_NEG;
      OP_NOT:          a = ALU_NOT;
      default:         a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register field plus enable to a one-hot
// R0..R15 strobe vector (all zero when disabled).
module reg_select_decoder (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore fetch/decode/execute sequencer for the single-bus datapath.
// Define CTRL_STEP_EN for single-step mode (PAUSE state + step input).
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned PC_INC     = 1,
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
`ifdef CTRL_STEP_EN
  input  logic        step,
`endif
  output logic [15:0] rin,
  output logic [15:0] rout,
  output logic        hi_in,
  output logic        lo_in,
  output logic        hi_out,
  output logic        lo_out,
  output logic        zhigh_in,
  output logic        zlow_in,
  output logic        zhigh_out,
  output logic        zlow_out,
  output logic        pc_in,
  output logic        pc_out,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        mar_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        cse_out,
  output logic        md_mux_read,
  output logic [31:0] c_sext,
  output logic [3:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        run,
  output logic        illegal
);

  state_t      state;
  logic [31:0] wait_cnt;
  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  class_t      cls;
  alu_op_t     alu_sel;
  logic [3:0]  rout_sel;
  logic        rout_en, rin_en;
  logic        in_wait, timeout;
  logic        unused_cfg;

  assign op     = ir[31:27];
  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];
  assign cls    = op_class(op);
  assign c_sext = {{13{ir[18]}}, ir[18:0]};
  assign alu_op = alu_sel;
  assign run    = clear || (state != S_HALT);

  // PC increment amount lives in the ALU; the sequencer only issues INC.
  assign unused_cfg = (PC_INC != 0);

  assign in_wait = (state == S_F2)
    || (state == S_T6 && cls == C_LD)
    || (state == S_T7 && cls == C_ST);

  assign timeout = (WAIT_LIMIT != 0)
    && (wait_cnt == 32'(WAIT_LIMIT - 1));

  localparam state_t DONE =
`ifdef CTRL_STEP_EN
    S_PAUSE;
`else
    S_F0;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_F0;
      wait_cnt <= '0;
    end else if (in_wait && !mem_ready) begin
      if (timeout) begin
        state    <= S_ABORT;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 32'd1;
      end
    end else begin
      wait_cnt <= '0;
      unique case (state)
        S_F0: state <= S_F1;
        S_F1: state <= S_F2;
        S_F2: state <= S_F3;
        S_F3: state <= S_T3;
        S_T3:
          unique case (cls)
            C_MFHI, C_MFLO, C_NOP:
              state <= DONE;
            C_HALT: state <= S_HALT;
            C_BAD:  state <= S_F0;
            default: state <= S_T4;
          endcase
        S_T4:
          state <= (cls == C_UNARY) ? DONE : S_T5;
        S_T5:
          state <= (cls == C_ALU || cls == C_IMM)
            ? DONE : S_T6;
        S_T6:
          state <= (cls == C_MULDIV) ? DONE : S_T7;
        S_T7:   state <= DONE;
        S_HALT: state <= S_HALT;
`ifdef CTRL_STEP_EN
        S_PAUSE: if (step) state <= S_F0;
`else
        S_PAUSE: state <= S_F0;
`endif
        S_ABORT: state <= S_F0;
        default: state <= S_F0;
      endcase
    end
  end

  always_comb begin
    hi_in = 1'b0; lo_in = 1'b0;
    hi_out = 1'b0; lo_out = 1'b0;
    zhigh_in = 1'b0; zlow_in = 1'b0;
    zhigh_out = 1'b0; zlow_out = 1'b0;
    pc_in = 1'b0; pc_out = 1'b0;
    mdr_in = 1'b0; mdr_out = 1'b0;
    mar_in = 1'b0; ir_in = 1'b0;
    y_in = 1'b0; cse_out = 1'b0;
    md_mux_read = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    illegal = 1'b0;
    alu_sel = ALU_ADD;
    rout_sel = rb;
    rout_en = 1'b0;
    rin_en = 1'b0;
    if (!clear) begin
      unique case (state)
        S_F0: begin
          pc_out = 1'b1; mar_in = 1'b1;
          alu_sel = ALU_INC; zlow_in = 1'b1;
        end
        S_F1: begin
          zlow_out = 1'b1; pc_in = 1'b1;
        end
        // MDR keeps loading Mdatain; the ready cycle's value sticks.
        S_F2: begin
          mem_read = 1'b1;
          md_mux_read = 1'b1; mdr_in = 1'b1;
        end
        S_F3: begin
          mdr_out = 1'b1; ir_in = 1'b1;
        end
        S_T3:
          unique case (cls)
            C_ALU, C_IMM: begin
              rout_en = 1'b1; y_in = 1'b1;
            end
            C_LD, C_ST: begin
              rout_en = (rb != 4'd0); y_in = 1'b1;
            end
            C_MULDIV: begin
              rout_sel = ra; rout_en = 1'b1;
              y_in = 1'b1;
            end
            C_UNARY: begin
              rout_en = 1'b1; alu_sel = op_alu(op);
              zlow_in = 1'b1;
            end
            C_MFHI: begin
              hi_out = 1'b1; rin_en = 1'b1;
            end
            C_MFLO: begin
              lo_out = 1'b1; rin_en = 1'b1;
            end
            C_BAD: illegal = 1'b1;
            default: ;
          endcase
        S_T4:
          unique case (cls)
            C_ALU: begin
              rout_sel = rc; rout_en = 1'b1;
              alu_sel = op_alu(op); zlow_in = 1'b1;
            end
            C_IMM: begin
              cse_out = 1'b1;
              alu_sel = op_alu(op); zlow_in = 1'b1;
            end
            C_MULDIV: begin
              rout_en = 1'b1; alu_sel = op_alu(op);
              zhigh_in = 1'b1; zlow_in = 1'b1;
            end
            C_UNARY: begin
              zlow_out = 1'b1; rin_en = 1'b1;
            end
            C_LD, C_ST: begin
              cse_out = 1'b1; zlow_in = 1'b1;
            end
            default: ;
          endcase
        S_T5:
          unique case (cls)
            C_ALU, C_IMM: begin
              zlow_out = 1'b1; rin_en = 1'b1;
            end
            C_MULDIV: begin
              zlow_out = 1'b1; lo_in = 1'b1;
            end
            C_LD, C_ST: begin
              zlow_out = 1'b1; mar_in = 1'b1;
            end
            default: ;
          endcase
        S_T6:
          unique case (cls)
            C_MULDIV: begin
              zhigh_out = 1'b1; hi_in = 1'b1;
            end
            C_LD: begin
              mem_read = 1'b1;
              md_mux_read = 1'b1; mdr_in = 1'b1;
            end
            C_ST: begin
              rout_sel = ra; rout_en = 1'b1;
              mdr_in = 1'b1;
            end
            default: ;
          endcase
        S_T7:
          unique case (cls)
            C_LD: begin
              mdr_out = 1'b1; rin_en = 1'b1;
            end
            C_ST: mem_write = 1'b1;
            default: ;
          endcase
        S_ABORT: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  reg_select_decoder u_rin (
    .sel    (ra),
    .en     (rin_en),
    .onehot (rin)
  );

  reg_select_decoder u_rout (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (rout)
  );

endmodule
